// File: rtl/ldvio_train.sv
// Load-violation predictor trainer: buffers violation reports, hashes them into the
// predictor RAM write port, and zeroes the table after reset and on a periodic decay sweep.
module ldvio_train #(
   parameter int unsigned DEPTH          = 16,
   parameter int unsigned INDEX          = 4,
   parameter int unsigned WIDTH          = 8,
   parameter int unsigned PC_WIDTH       = 32,
   parameter int unsigned FIFO_DEPTH     = 4,
   parameter int unsigned CLEAR_INTERVAL = 64
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                vio0Valid_i,
   input  logic [PC_WIDTH-1:0] vio0PC_i,
   input  logic                vio1Valid_i,
   input  logic [PC_WIDTH-1:0] vio1PC_i,
   output logic                we_o,
   output logic [INDEX-1:0]    addr_o,
   output logic [WIDTH-1:0]    data_o,
   output logic                initDone_o,
   output logic [7:0]          dropCount_o
);
   localparam int unsigned FPW = $clog2(FIFO_DEPTH);
   localparam int unsigned IVW = $clog2(CLEAR_INTERVAL + 1);
   localparam int unsigned EW  = INDEX + WIDTH - 1;

   typedef enum logic [1:0] {StInit, StIdle, StClear} state_e;

   state_e           state_q, state_d;
   logic [INDEX-1:0] ptr_q, ptr_d;
   logic [IVW-1:0]   ival_q, ival_d;
   logic             we_q, we_d;
   logic [INDEX-1:0] addr_q, addr_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             init_done_q, init_done_d;
   logic [7:0]       drop_cnt_q, drop_cnt_d;
   logic [EW-1:0]    fifo_q [FIFO_DEPTH];
   logic [EW-1:0]    fifo_d [FIFO_DEPTH];
   logic [FPW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [FPW:0]     cnt_q, cnt_d, space;
   logic [EW-1:0]    ent0, ent1, head;
   logic [INDEX-1:0] evt_addr;
   logic [WIDTH-1:0] evt_data;
   logic             push0, push1, pop;
   logic [1:0]       drops;
   logic [8:0]       drop_sum;
   logic             unused_pc_bits;

   // FIFO entry layout: {index, tag}
   function automatic logic [EW-1:0] hash(input logic [PC_WIDTH-1:0] pc);
      return {pc[INDEX+1:2] ^ pc[2*INDEX+1:INDEX+2], pc[2*INDEX+2 +: WIDTH-1]};
   endfunction

   assign unused_pc_bits = ^{vio0PC_i, vio1PC_i};

   always_comb begin
      ent0     = hash(vio0PC_i);
      ent1     = hash(vio1PC_i);
      head     = fifo_q[rd_ptr_q];
      evt_addr = head[EW-1 -: INDEX];
      evt_data = {1'b1, head[WIDTH-2:0]};
      // Space is judged at the start of the cycle; a same-cycle pop earns no credit.
      space    = (state_q == StInit) ? '0 : (FPW+1)'(FIFO_DEPTH) - cnt_q;
      push0    = vio0Valid_i && (space != '0);
      push1    = vio1Valid_i && (space > (FPW+1)'(push0));
      pop      = (state_q != StInit) && (cnt_q != '0);
      drops    = 2'(vio0Valid_i) + 2'(vio1Valid_i) - 2'(push0) - 2'(push1);
      drop_sum = 9'(drop_cnt_q) + 9'(drops);
      drop_cnt_d = drop_sum[8] ? 8'hFF : drop_sum[7:0];
      fifo_d = fifo_q;
      if (push0) fifo_d[wr_ptr_q] = ent0;
      if (push1) fifo_d[wr_ptr_q + FPW'(push0)] = ent1;
      wr_ptr_d = wr_ptr_q + FPW'(push0) + FPW'(push1);
      rd_ptr_d = rd_ptr_q + FPW'(pop);
      cnt_d    = cnt_q + (FPW+1)'(push0) + (FPW+1)'(push1) - (FPW+1)'(pop);
   end

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      ival_d      = ival_q;
      init_done_d = init_done_q;
      we_d        = 1'b0;
      addr_d      = '0;
      data_d      = '0;
      case (state_q)
         StInit: begin
            we_d   = 1'b1;
            addr_d = ptr_q;
            if (ptr_q == INDEX'(DEPTH - 1)) begin
               state_d     = StIdle;
               ptr_d       = '0;
               init_done_d = 1'b1;
            end else begin
               ptr_d = ptr_q + INDEX'(1);
            end
         end
         StIdle: begin
            if (pop) begin
               we_d   = 1'b1;
               addr_d = evt_addr;
               data_d = evt_data;
            end
            if (ival_q == IVW'(CLEAR_INTERVAL - 1)) begin
               state_d = StClear;
               ptr_d   = '0;
               ival_d  = '0;
            end else begin
               ival_d = ival_q + IVW'(1);
            end
         end
         StClear: begin
            // Pending events win; the sweep pointer waits for a free cycle.
            if (pop) begin
               we_d   = 1'b1;
               addr_d = evt_addr;
               data_d = evt_data;
            end else begin
               we_d   = 1'b1;
               addr_d = ptr_q;
               if (ptr_q == INDEX'(DEPTH - 1)) begin
                  state_d = StIdle;
                  ptr_d   = '0;
                  ival_d  = '0;
               end else begin
                  ptr_d = ptr_q + INDEX'(1);
               end
            end
         end
         default: state_d = StInit;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= StInit;
         ptr_q       <= '0;
         ival_q      <= '0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         data_q      <= '0;
         init_done_q <= 1'b0;
         drop_cnt_q  <= '0;
         fifo_q      <= '{default: '0};
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         ival_q      <= ival_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         data_q      <= data_d;
         init_done_q <= init_done_d;
         drop_cnt_q  <= drop_cnt_d;
         fifo_q      <= fifo_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         cnt_q       <= cnt_d;
      end
   end

   assign we_o        = we_q;
   assign addr_o      = addr_q;
   assign data_o      = data_q;
   assign initDone_o  = init_done_q;
   assign dropCount_o = drop_cnt_q;

endmodule
